// File: rtl/ps2_scan_history.sv
// Purpose : PS/2 scancode front end. Keeps a shift history of the last DEPTH bytes
//           and folds E0 (extended) / F0 (break) prefixes into single key events.
// Latency : one cycle, strobe at edge N -> history/hist_count/key_* valid after edge N.
// Backpressure: none, accepts one byte per cycle at full rate; clear wins over a strobe.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   received_data_en/_data  one-cycle byte strobe from the PS/2 byte receiver
//   clear                   synchronous clear of history, count, FSM and key outputs
//   history/hist_count      byte k at [k*DATA_W +: DATA_W], k=0 newest; valid-entry count
//   key_valid               one-cycle pulse per completed key event
//   key_code/break/ext      event fields, held until the next event
module ps2_scan_history #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 4,
    parameter logic [DATA_W-1:0] BREAK_CODE = 8'hF0,
    parameter logic [DATA_W-1:0] EXT_CODE   = 8'hE0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       received_data_en,
    input  logic [DATA_W-1:0]          received_data,
    input  logic                       clear,
    output logic [DEPTH*DATA_W-1:0]    history,
    output logic [$clog2(DEPTH+1)-1:0] hist_count,
    output logic                       key_valid,
    output logic [DATA_W-1:0]          key_code,
    output logic                       key_break,
    output logic                       key_ext
);

    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

    // State encodes the two pending-prefix flags (ext, brk).
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t                    state_q, state_d;
    logic [DEPTH*DATA_W-1:0]   hist_q, hist_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      vld_q, vld_d;
    logic [DATA_W-1:0]         code_q, code_d;
    logic                      brk_q, brk_d;
    logic                      ext_q, ext_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            code_q  <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            code_q  <= code_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        code_d  = code_q;
        brk_d   = brk_q;
        ext_d   = ext_q;

        if (clear) begin
            state_d = ST_IDLE;
            hist_d  = '0;
            cnt_d   = '0;
            code_d  = '0;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
        end else if (received_data_en) begin
            // Zeros shift in behind the newest byte, so slots at or above
            // hist_count always read 0 without extra masking.
            hist_d = {hist_q[(DEPTH-1)*DATA_W-1:0], received_data};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end

            if (received_data == EXT_CODE) begin
                case (state_q)
                    ST_IDLE: state_d = ST_EXT;
                    ST_BRK:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else if (received_data == BREAK_CODE) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                vld_d   = 1'b1;
                code_d  = received_data;
                brk_d   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                ext_d   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                state_d = ST_IDLE;
            end
        end
    end

    assign history    = hist_q;
    assign hist_count = cnt_q;
    assign key_valid  = vld_q;
    assign key_code   = code_q;
    assign key_break  = brk_q;
    assign key_ext    = ext_q;

endmodule

// File: tb/tb_ps2_scan_history.sv
module tb_ps2_scan_history;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH+1);

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    received_data_en = 1'b0;
    logic [DATA_W-1:0]       received_data = '0;
    logic                    clear = 1'b0;
    logic [DEPTH*DATA_W-1:0] history;
    logic [CW-1:0]           hist_count;
    logic                    key_valid;
    logic [DATA_W-1:0]       key_code;
    logic                    key_break;
    logic                    key_ext;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ps2_scan_history #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)
    ) dut (
        .clock(clock), .reset(reset),
        .received_data_en(received_data_en), .received_data(received_data),
        .clear(clear), .history(history), .hist_count(hist_count),
        .key_valid(key_valid), .key_code(key_code),
        .key_break(key_break), .key_ext(key_ext)
    );

    always #5 clock = ~clock;

    // Behavioural model: newest-first byte list plus pending prefix flags.
    logic [7:0] m_hist [DEPTH];
    int         m_cnt;
    bit         m_pend_ext, m_pend_brk;
    bit         m_vld, m_brk, m_ext;
    logic [7:0] m_code;

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) m_hist[k] = 8'h00;
        m_cnt = 0; m_pend_ext = 0; m_pend_brk = 0;
        m_vld = 0; m_code = 8'h00; m_brk = 0; m_ext = 0;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            model_clear();
        end else if (received_data_en) begin
            for (int k = DEPTH-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = received_data;
            m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
            m_vld = 0;
            if (received_data == 8'hE0)      m_pend_ext = 1;
            else if (received_data == 8'hF0) m_pend_brk = 1;
            else begin
                m_vld = 1; m_code = received_data;
                m_brk = m_pend_brk; m_ext = m_pend_ext;
                m_pend_brk = 0; m_pend_ext = 0;
            end
        end else begin
            m_vld = 0;
        end
    end

    function automatic logic [7:0] slot(input int k);
        return history[k*DATA_W +: DATA_W];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("m_key_valid", 32'(key_valid), 32'(m_vld));
            cmp("m_key_code",  32'(key_code),  32'(m_code));
            cmp("m_key_break", 32'(key_break), 32'(m_brk));
            cmp("m_key_ext",   32'(key_ext),   32'(m_ext));
            cmp("m_hist_count", 32'(hist_count), 32'(m_cnt));
            for (int k = 0; k < DEPTH; k++)
                cmp($sformatf("m_history%0d", k), 32'(slot(k)), 32'(m_hist[k]));
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that took the byte.
    task automatic strobe(input logic [7:0] b);
        received_data_en = 1'b1;
        received_data    = b;
        @(posedge clock); #1;
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_event(input string name, input logic [7:0] c, input bit brk, input bit ext);
        cmp({name, "_valid"}, 32'(key_valid), 32'd1);
        cmp({name, "_code"},  32'(key_code),  32'(c));
        cmp({name, "_break"}, 32'(key_break), 32'(brk));
        cmp({name, "_ext"},   32'(key_ext),   32'(ext));
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Reset state
        cmp("rst_valid", 32'(key_valid), 32'd0);
        cmp("rst_code",  32'(key_code),  32'd0);
        cmp("rst_count", 32'(hist_count), 32'd0);
        cmp("rst_hist",  32'(history),   32'd0);
        idle(1);

        // Plain make
        strobe(8'h1C);
        check_event("make", 8'h1C, 0, 0);
        cmp("make_slot0", 32'(slot(0)), 32'h1C);
        cmp("make_count", 32'(hist_count), 32'd1);
        idle(1);
        cmp("make_pulse_end", 32'(key_valid), 32'd0);

        // Break F0 1C back-to-back
        strobe(8'hF0);
        cmp("brk_prefix_novalid", 32'(key_valid), 32'd0);
        strobe(8'h1C);
        check_event("brk", 8'h1C, 1, 0);
        cmp("brk_slot0", 32'(slot(0)), 32'h1C);
        cmp("brk_slot1", 32'(slot(1)), 32'hF0);
        idle(2);

        // Extended-break in both prefix orders, and repeated E0
        strobe(8'hE0); strobe(8'hF0);
        cmp("eb_prefix_novalid", 32'(key_valid), 32'd0);
        strobe(8'h75);
        check_event("ext_brk", 8'h75, 1, 1);
        idle(1);
        strobe(8'hF0); strobe(8'hE0); strobe(8'h75);
        check_event("brk_ext", 8'h75, 1, 1);
        strobe(8'hE0); strobe(8'hE0); strobe(8'h75);
        check_event("ext_ext", 8'h75, 0, 1);
        // Back-to-back events: key_valid high on consecutive cycles
        strobe(8'h12);
        check_event("b2b", 8'h12, 0, 0);
        idle(1);

        // History saturation after clear
        clear = 1'b1; idle(1); clear = 1'b0;
        cmp("clr_count", 32'(hist_count), 32'd0);
        cmp("clr_code",  32'(key_code),   32'd0);
        strobe(8'h11); strobe(8'h22); strobe(8'h33);
        cmp("part_count", 32'(hist_count), 32'd3);
        cmp("part_slot3", 32'(slot(3)), 32'h00);
        strobe(8'h44); strobe(8'h55);
        cmp("sat_hist",  32'(history), 32'h22334455);
        cmp("sat_count", 32'(hist_count), 32'd4);
        idle(1);

        // Async reset mid-sequence discards the pending prefix
        strobe(8'hF0);
        reset = 1'b1; #3; reset = 1'b0;
        cmp("arst_count", 32'(hist_count), 32'd0);
        idle(1);
        strobe(8'h1C);
        check_event("after_rst", 8'h1C, 0, 0);
        idle(1);

        // Clear together with a strobe: clear wins, byte dropped
        strobe(8'hF0);
        clear = 1'b1; received_data_en = 1'b1; received_data = 8'h1C;
        idle(1);
        clear = 1'b0; received_data_en = 1'b0;
        cmp("clrstb_valid", 32'(key_valid), 32'd0);
        cmp("clrstb_count", 32'(hist_count), 32'd0);
        strobe(8'h1C);
        check_event("after_clr", 8'h1C, 0, 0);
        idle(2);

        // Gapped strobe, then long idle: pulse one cycle wide, code held
        strobe(8'h1C);
        check_event("gap", 8'h1C, 0, 0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            cmp("idle_valid", 32'(key_valid), 32'd0);
            cmp("idle_code",  32'(key_code),  32'h1C);
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_history.md
# ps2_scan_history

Parametrised PS/2 scancode front end that sits directly after the PS/2 byte receiver. It keeps a shift history of the last DEPTH received bytes. It also runs a small prefix-decoding FSM that folds extended (E0) and break (F0) prefixes into single key events with make/break and extended flags. Downstream game logic (click/upgrade key handling) consumes `key_valid` events instead of raw byte pairs.

## Interface
- DATA_W, 8, width of one received byte
- DEPTH, 4, number of bytes kept in history (≥2)
- BREAK_CODE, 8'hF0, break prefix value
- EXT_CODE, 8'hE0, extended prefix value

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- received_data_en  in  1  one-cycle strobe: `received_data` is a new byte
- received_data  in  DATA_W  byte from PS/2 receiver
- clear  in  1  synchronous clear of history, count and FSM
- history  out  DEPTH*DATA_W  byte k (bits [k*DATA_W +: DATA_W]) = k-th most recent byte, k=0 newest
- hist_count  out  $clog2(DEPTH+1)  number of valid history entries, saturates at DEPTH
- key_valid  out  1  one-cycle pulse: completed key event
- key_code  out  DATA_W  scancode of the event (non-prefix byte)
- key_break  out  1  event is a release (break prefix seen)
- key_ext  out  1  event is extended (extended prefix seen)

## Operation
- History: on each accepted byte, history shifts up one slot (oldest dropped), new byte enters slot 0. All bytes, including prefixes, enter history. hist_count increments per accepted byte and saturates at DEPTH.
- Slots at index ≥ hist_count read 0.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Two internal flags are effectively encoded: ext, brk.
- Byte == EXT_CODE: set ext. IDLE→EXT, BRK→EXT_BRK. EXT and EXT_BRK hold.
- Byte == BREAK_CODE: set brk. IDLE→BRK, EXT→EXT_BRK. BRK and EXT_BRK hold.
- Repeated prefixes are idempotent.
- Any other byte:
  - Emit event: key_valid=1, key_code=byte, key_break=brk, key_ext=ext.
  - FSM returns to IDLE.
- key_code/key_break/key_ext hold their last event values until the next event. Only key_valid pulses.
- No received_data_en: nothing changes; key_valid=0.
- clear=1: history all 0, hist_count=0, FSM→IDLE, key_valid=0. key_code/key_break/key_ext cleared to 0.
- clear and received_data_en in the same cycle: clear wins; the byte is dropped.
- Reset values: history=0, hist_count=0, key_valid=0, key_code=0, key_break=0, key_ext=0, FSM=IDLE.

## Timing
- All outputs registered.
- A byte strobed at edge N appears in history[slot 0] and hist_count after edge N.
- Its key event (if any) has key_valid high for exactly the cycle after edge N.
- Back-to-back strobes on consecutive cycles are supported at full rate. Each strobe is processed independently, and key_valid may be high on consecutive cycles.
- Prefix bytes produce no key_valid.
- An event completes in the same cycle as its final byte's strobe; there is no extra latency for prefixed sequences.
- Asynchronous reset mid-sequence (e.g. after F0, before the code) discards the pending prefix. The next non-prefix byte is then reported as a plain make.

## Test plan
- Reset then strobe 8'h1C → key_valid pulse, key_code=1C, key_break=0, key_ext=0; history slot0=1C, hist_count=1.
- Strobe F0, 1C on consecutive cycles → single key_valid on the second, key_code=1C, key_break=1, key_ext=0; history slot0=1C, slot1=F0.
- Strobe E0, F0, 75 → one event, code=75, break=1, ext=1. Also test F0, E0, 75 → same result. Also test E0, E0, 75 → ext=1, break=0.
- DEPTH=4: strobe 11, 22, 33, 44, 55 → history slots0..3 = 55, 44, 33, 22; hist_count=4 (saturated).
- Strobe F0, assert reset, release, strobe 1C → event code=1C, break=0. Separately: strobe F0, assert clear together with a 1C strobe → no event, hist_count=0. Then strobe 1C → plain make.
- Strobe 1C with gaps, then idle 10 cycles → key_valid exactly one cycle wide; key_code holds 1C throughout idle.
